// File: rtl/cw305_mailbox_ctrl.sv
// Host/core mailbox handshake controller: synchronizes host flags, buffers host
// words in a small RX FIFO and posts core responses back to the host one at a time.
module cw305_mailbox_ctrl #(
    parameter int pDEPTH   = 4,
    parameter int pTIMEOUT = 65535
) (
    input  logic                      crypto_clk,
    input  logic                      reset_n,
    input  logic [31:0]               I_ext_data,
    input  logic [31:0]               I_ext_flags,
    output logic [31:0]               O_pulpino_data,
    output logic [31:0]               O_pulpino_flags,
    output logic [31:0]               O_rx_data,
    output logic                      O_rx_valid,
    input  logic                      I_rx_ready,
    input  logic [31:0]               I_tx_data,
    input  logic                      I_tx_valid,
    output logic                      O_tx_ready,
    output logic [$clog2(pDEPTH):0]   O_rx_level,
    input  logic                      I_err_clear
);

    localparam int          AW      = $clog2(pDEPTH);
    localparam logic [15:0] TO_LAST = 16'(pTIMEOUT - 1);
    localparam logic [AW:0] LVL_MAX = (AW + 1)'(pDEPTH);

    typedef enum logic       {R_IDLE, R_WAIT_CLR}        rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_POST, T_RELEASE} tx_state_t;

    logic [2:0] sync_q1, sync_q2;
    logic       valid_s, ack_s, abort_s;
    logic       unused_flags;

    rx_state_t  rx_state, rx_next;
    tx_state_t  tx_state, tx_next;
    logic [15:0] rx_cnt, tx_cnt;
    logic       rx_last, tx_last, rx_to, tx_to;
    logic       ack, resp_valid, tx_ready, tx_fire;
    logic       timeout_err;

    logic [31:0]   mem [pDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          full, push, pop;

    assign unused_flags = ^I_ext_flags[31:3];

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= I_ext_flags[2:0];
            sync_q2 <= sync_q1;
        end
    end

    assign valid_s = sync_q2[0];
    assign ack_s   = sync_q2[1];
    assign abort_s = sync_q2[2];

    // ---------------- RX handshake ----------------
    assign full    = (level == LVL_MAX);
    assign rx_last = (rx_cnt == TO_LAST);
    assign push    = (rx_state == R_IDLE) && valid_s && !full && !abort_s;
    assign rx_to   = (rx_state == R_WAIT_CLR) && valid_s && rx_last && !abort_s;

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) rx_state <= R_IDLE;
        else          rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        if (abort_s) begin
            rx_next = R_IDLE;
        end else begin
            case (rx_state)
                R_IDLE:     if (push) rx_next = R_WAIT_CLR;
                R_WAIT_CLR: if (!valid_s || rx_last) rx_next = R_IDLE;
                default:    rx_next = R_IDLE;
            endcase
        end
    end

    always_comb begin
        ack = (rx_state == R_WAIT_CLR);
    end

    // Counters restart on every state change, so each waiting state gets a fresh budget.
    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n)                             rx_cnt <= '0;
        else if (abort_s || rx_next != rx_state)  rx_cnt <= '0;
        else if (rx_state == R_WAIT_CLR)          rx_cnt <= rx_cnt + 16'd1;
    end

    // ---------------- TX handshake ----------------
    assign tx_ready = (tx_state == T_IDLE) && !abort_s;
    assign tx_fire  = I_tx_valid && tx_ready;
    assign tx_last  = (tx_cnt == TO_LAST);
    assign tx_to    = !abort_s && tx_last &&
                      (((tx_state == T_POST) && !ack_s) || ((tx_state == T_RELEASE) && ack_s));

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) tx_state <= T_IDLE;
        else          tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        if (abort_s) begin
            tx_next = T_IDLE;
        end else begin
            case (tx_state)
                T_IDLE:    if (tx_fire) tx_next = T_POST;
                T_POST:    if (ack_s) tx_next = T_RELEASE;
                           else if (tx_last) tx_next = T_IDLE;
                T_RELEASE: if (!ack_s || tx_last) tx_next = T_IDLE;
                default:   tx_next = T_IDLE;
            endcase
        end
    end

    always_comb begin
        resp_valid = (tx_state == T_POST);
        O_tx_ready = tx_ready;
    end

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n)                             tx_cnt <= '0;
        else if (abort_s || tx_next != tx_state)  tx_cnt <= '0;
        else if (tx_state != T_IDLE)              tx_cnt <= tx_cnt + 16'd1;
    end

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n)     O_pulpino_data <= '0;
        else if (tx_fire) O_pulpino_data <= I_tx_data;
    end

    // A fresh timeout outranks a clear requested in the same cycle.
    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n)            timeout_err <= 1'b0;
        else if (rx_to || tx_to) timeout_err <= 1'b1;
        else if (I_err_clear)    timeout_err <= 1'b0;
    end

    // ---------------- RX FIFO ----------------
    assign pop = (level != '0) && I_rx_ready && !abort_s;

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < pDEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= I_ext_data;
        end
    end

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort_s) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    assign O_rx_data       = mem[rd_ptr];
    assign O_rx_valid      = (level != '0);
    assign O_rx_level      = level;
    assign O_pulpino_flags = {28'd0, timeout_err, full, resp_valid, ack};

endmodule

// File: tb/tb_cw305_mailbox_ctrl.sv
// Directed plus randomized bench for cw305_mailbox_ctrl against a transaction-level
// model (queue of buffered words, sticky error flag, last posted response).
module tb_cw305_mailbox_ctrl;

    localparam int DEPTH = 4;
    localparam int TOUT  = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ext_data, ext_flags, pulpino_data, pulpino_flags, rx_data, tx_data;
    logic        rx_valid, rx_ready, tx_valid, tx_ready, err_clear;
    logic [2:0]  rx_level;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q[$];
    logic        err_m = 1'b0;
    logic [31:0] last_tx = '0;

    cw305_mailbox_ctrl #(.pDEPTH(DEPTH), .pTIMEOUT(TOUT)) dut (
        .crypto_clk(clk), .reset_n(reset_n),
        .I_ext_data(ext_data), .I_ext_flags(ext_flags),
        .O_pulpino_data(pulpino_data), .O_pulpino_flags(pulpino_flags),
        .O_rx_data(rx_data), .O_rx_valid(rx_valid), .I_rx_ready(rx_ready),
        .I_tx_data(tx_data), .I_tx_valid(tx_valid), .O_tx_ready(tx_ready),
        .O_rx_level(rx_level), .I_err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic ack, input logic resp);
        logic full_m;
        full_m = (q.size() == DEPTH);
        check({tag, "_flags"}, pulpino_flags, {28'd0, err_m, full_m, resp, ack});
    endtask

    task automatic chk_fifo(input string tag);
        check({tag, "_level"}, 32'(rx_level), 32'(q.size()));
        check({tag, "_rxvalid"}, 32'(rx_valid), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, "_head"}, rx_data, q[0]);
    endtask

    // Full four-phase host write; caller guarantees the model has room.
    task automatic host_write(input logic [31:0] w);
        ext_data = w;
        ext_flags[0] = 1'b1;
        step(2);
        chk_flags("wr_pre", 1'b0, 1'b0);
        step(1);
        q.push_back(w);
        chk_flags("wr_ack", 1'b1, 1'b0);
        chk_fifo("wr");
        ext_flags[0] = 1'b0;
        step(2);
        chk_flags("wr_hold", 1'b1, 1'b0);
        step(1);
        chk_flags("wr_rel", 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        chk_fifo("pop");
    endtask

    task automatic core_resp(input logic [31:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        last_tx  = w;
        check("tx_busy", 32'(tx_ready), 32'd0);
        check("tx_data", pulpino_data, w);
        chk_flags("tx_post", 1'b0, 1'b1);
        ext_flags[1] = 1'b1;
        step(2);
        chk_flags("tx_wait", 1'b0, 1'b1);
        step(1);
        chk_flags("tx_acked", 1'b0, 1'b0);
        check("tx_rel_busy", 32'(tx_ready), 32'd0);
        ext_flags[1] = 1'b0;
        step(2);
        check("tx_rel_hold", 32'(tx_ready), 32'd0);
        step(1);
        check("tx_idle", 32'(tx_ready), 32'd1);
        check("tx_data_hold", pulpino_data, last_tx);
    endtask

    initial begin
        reset_n = 1'b0; ext_data = '0; ext_flags = '0; rx_ready = 1'b0;
        tx_data = '0; tx_valid = 1'b0; err_clear = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        // reset state
        chk_flags("rst", 1'b0, 1'b0);
        chk_fifo("rst");
        check("rst_rxdata", rx_data, 32'd0);
        check("rst_pdata", pulpino_data, 32'd0);
        check("rst_txready", 32'(tx_ready), 32'd1);

        // single host write
        host_write(32'hDEADBEEF);
        pop_one();

        // fill to depth, fifth write withheld until a pop frees a slot
        for (int i = 0; i < DEPTH; i++) host_write(32'h1000_0000 + 32'(i));
        ext_data = 32'hF1F1F1F1;
        ext_flags[0] = 1'b1;
        step(6);
        chk_flags("full_hold", 1'b0, 1'b0);
        chk_fifo("full_hold");
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        void'(q.pop_front());
        chk_flags("full_pop", 1'b0, 1'b0);
        chk_fifo("full_pop");
        step(1);
        q.push_back(32'hF1F1F1F1);
        chk_flags("full_cap", 1'b1, 1'b0);
        chk_fifo("full_cap");
        ext_flags[0] = 1'b0;
        step(3);
        chk_flags("full_rel", 1'b0, 1'b0);
        while (q.size() != 0) pop_one();

        // core response
        core_resp(32'h12345678);

        // simultaneous push and pop at level 2
        host_write(32'hA0A0A0A0);
        host_write(32'hB1B1B1B1);
        ext_data = 32'hC2C2C2C2;
        ext_flags[0] = 1'b1;
        step(2);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(32'hC2C2C2C2);
        chk_flags("pp_ack", 1'b1, 1'b0);
        chk_fifo("pp");
        ext_flags[0] = 1'b0;
        step(3);
        pop_one();
        pop_one();

        // tx timeout with err_clear colliding on the firing edge
        tx_data = 32'h0BADF00D;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        step(TOUT - 1);
        chk_flags("to_before", 1'b0, 1'b1);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        err_m = 1'b1;
        chk_flags("to_fire", 1'b0, 1'b0);
        check("to_txready", 32'(tx_ready), 32'd1);

        // abort with three buffered words and a posted response
        host_write(32'h33330001);
        host_write(32'h33330002);
        host_write(32'h33330003);
        tx_data = 32'hABCD0123;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        chk_flags("ab_pre", 1'b0, 1'b1);
        ext_flags[2] = 1'b1;
        step(2);
        check("ab_txready", 32'(tx_ready), 32'd0);
        step(1);
        q.delete();
        chk_fifo("ab");
        chk_flags("ab", 1'b0, 1'b0);
        tx_data = 32'hA5A5A5A5;
        tx_valid = 1'b1;
        step(3);
        check("ab_noxfer", pulpino_data, 32'hABCD0123);
        check("ab_txready_hold", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        ext_flags[2] = 1'b0;
        step(3);
        check("ab_release", 32'(tx_ready), 32'd1);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        err_m = 1'b0;
        chk_flags("errclr", 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: if (q.size() < DEPTH) host_write($urandom); else pop_one();
                1: pop_one();
                default: core_resp($urandom);
            endcase
        end

        // asynchronous reset in the middle of a handshake
        while (q.size() > 2) pop_one();
        ext_data = 32'h55AA55AA;
        ext_flags[0] = 1'b1;
        step(3);
        #2 reset_n = 1'b0;
        #1;
        q.delete();
        err_m = 1'b0;
        chk_flags("arst", 1'b0, 1'b0);
        chk_fifo("arst");
        check("arst_rxdata", rx_data, 32'd0);
        check("arst_pdata", pulpino_data, 32'd0);
        check("arst_txready", 32'(tx_ready), 32'd1);
        ext_flags = '0;
        step(3);
        reset_n = 1'b1;
        step(1);
        chk_fifo("arst_rel");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
